// File: rtl/baccarat_deal_fsm.sv
// Baccarat hand sequencer: card-load strobes in deal order, third-card rules,
// latched winner lights and saturating win/tie tallies that persist across hands.
module baccarat_deal_fsm #(
  parameter int TALLY_W = 4
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               step,
  input  logic               new_hand,
  input  logic [3:0]         pscore,
  input  logic [3:0]         dscore,
  input  logic [3:0]         pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               clear_hand,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               hand_done,
  output logic [TALLY_W-1:0] pwins,
  output logic [TALLY_W-1:0] dwins,
  output logic [TALLY_W-1:0] ties,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_P1   = 4'd0,
    S_D1   = 4'd1,
    S_P2   = 4'd2,
    S_D2   = 4'd3,
    S_NAT  = 4'd4,
    S_P3   = 4'd5,
    S_BANK = 4'd6,
    S_D3   = 4'd7,
    S_RES  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t     state, state_nx;
  logic       player_drew, player_drew_nx;
  logic [3:0] v3;
  logic       banker_draw;
  logic       res_fire;
  logic       new_fire;

  // Face cards (10..13) count as zero for the banker's third-card table.
  always_comb begin
    v3 = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  end

  always_comb begin
    banker_draw = 1'b0;
    if (!player_drew) begin
      banker_draw = (dscore <= 4'd5);
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
        4'd3:             banker_draw = (v3 != 4'd8);
        4'd4:             banker_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
        4'd5:             banker_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
        4'd6:             banker_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
        default:          banker_draw = 1'b0;
      endcase
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= S_P1;
      player_drew <= 1'b0;
    end else begin
      state       <= state_nx;
      player_drew <= player_drew_nx;
    end
  end

  // step is the only advance qualifier; S_DONE waits on new_hand alone.
  always_comb begin
    state_nx       = state;
    player_drew_nx = player_drew;
    case (state)
      S_P1: if (step) state_nx = S_D1;
      S_D1: if (step) state_nx = S_P2;
      S_P2: if (step) state_nx = S_D2;
      S_D2: if (step) state_nx = S_NAT;
      S_NAT: begin
        if (step) begin
          if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
            state_nx = S_RES;
          end else if (pscore <= 4'd5) begin
            state_nx       = S_P3;
            player_drew_nx = 1'b1;
          end else begin
            state_nx       = S_BANK;
            player_drew_nx = 1'b0;
          end
        end
      end
      S_P3: if (step) state_nx = S_BANK;
      S_BANK: begin
        if (step) state_nx = banker_draw ? S_D3 : S_RES;
      end
      S_D3:  if (step) state_nx = S_RES;
      S_RES: if (step) state_nx = S_DONE;
      S_DONE: begin
        if (new_hand) begin
          state_nx       = S_P1;
          player_drew_nx = 1'b0;
        end
      end
      default: state_nx = S_P1;
    endcase
  end

  // Strobes are gated by resetb so every output reads 0 while reset is held.
  always_comb begin
    load_pcard1 = resetb & step & (state == S_P1);
    load_dcard1 = resetb & step & (state == S_D1);
    load_pcard2 = resetb & step & (state == S_P2);
    load_dcard2 = resetb & step & (state == S_D2);
    load_pcard3 = resetb & step & (state == S_P3);
    load_dcard3 = resetb & step & (state == S_D3);
    clear_hand  = resetb & new_hand & (state == S_DONE);
    hand_done   = (state == S_DONE);
    state_dbg   = state;
  end

  assign res_fire = step & (state == S_RES);
  assign new_fire = new_hand & (state == S_DONE);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      pwins            <= '0;
      dwins            <= '0;
      ties             <= '0;
    end else if (res_fire) begin
      player_win_light <= (pscore >= dscore);
      dealer_win_light <= (dscore >= pscore);
      if (pscore > dscore) begin
        if (pwins != '1) pwins <= pwins + TALLY_W'(1);
      end else if (dscore > pscore) begin
        if (dwins != '1) dwins <= dwins + TALLY_W'(1);
      end else begin
        if (ties != '1) ties <= ties + TALLY_W'(1);
      end
    end else if (new_fire) begin
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baccarat_deal_fsm.sv
// Directed table-driven bench for baccarat_deal_fsm; the bench plays the datapath
// by driving pscore/dscore/pcard3 directly, and uses 2-bit tallies to reach saturation.
module tb_baccarat_deal_fsm;

  localparam int TW = 2;

  logic          clk;
  logic          resetb;
  logic          step;
  logic          new_hand;
  logic [3:0]    pscore, dscore, pcard3;
  logic          load_pcard1, load_pcard2, load_pcard3;
  logic          load_dcard1, load_dcard2, load_dcard3;
  logic          clear_hand, player_win_light, dealer_win_light, hand_done;
  logic [TW-1:0] pwins, dwins, ties;
  logic [3:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          step;
    logic          nh;
    logic [3:0]    p;
    logic [3:0]    d;
    logic [3:0]    c3;
    logic [3:0]    st;
    logic [5:0]    ld;   // {lp1, lp2, lp3, ld1, ld2, ld3}
    logic          clr;
    logic          pl;
    logic          dl;
    logic          done;
    logic [TW-1:0] pw;
    logic [TW-1:0] dw;
    logic [TW-1:0] ti;
  } vec_t;

  vec_t tbl[$];

  baccarat_deal_fsm #(.TALLY_W(TW)) dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .step             (step),
    .new_hand         (new_hand),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .clear_hand       (clear_hand),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .hand_done        (hand_done),
    .pwins            (pwins),
    .dwins            (dwins),
    .ties             (ties),
    .state_dbg        (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic nh, input logic [3:0] p,
                              input logic [3:0] d, input logic [3:0] c3,
                              input logic [3:0] st, input logic [5:0] ld, input logic clr,
                              input logic pl, input logic dl, input logic done,
                              input logic [TW-1:0] pw, input logic [TW-1:0] dw,
                              input logic [TW-1:0] ti);
    vec_t v;
    v.step = s; v.nh = nh; v.p = p; v.d = d; v.c3 = c3;
    v.st = st; v.ld = ld; v.clr = clr; v.pl = pl; v.dl = dl; v.done = done;
    v.pw = pw; v.dw = dw; v.ti = ti;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".state"}, 16'(state_dbg), 16'(v.st));
    chk({tag, ".loads"}, 16'({load_pcard1, load_pcard2, load_pcard3,
                              load_dcard1, load_dcard2, load_dcard3}), 16'(v.ld));
    chk({tag, ".clear"}, 16'(clear_hand), 16'(v.clr));
    chk({tag, ".plight"}, 16'(player_win_light), 16'(v.pl));
    chk({tag, ".dlight"}, 16'(dealer_win_light), 16'(v.dl));
    chk({tag, ".done"}, 16'(hand_done), 16'(v.done));
    chk({tag, ".pwins"}, 16'(pwins), 16'(v.pw));
    chk({tag, ".dwins"}, 16'(dwins), 16'(v.dw));
    chk({tag, ".ties"}, 16'(ties), 16'(v.ti));
  endtask

  // One row = one clock cycle: inputs driven after the edge, outputs checked mid-cycle.
  task automatic apply(input string tag, input vec_t v);
    @(posedge clk);
    #1;
    step = v.step; new_hand = v.nh; pscore = v.p; dscore = v.d; pcard3 = v.c3;
    @(negedge clk);
    chk_all(tag, v);
  endtask

  task automatic deal4(input logic [3:0] p, input logic [3:0] d, input logic [TW-1:0] pw,
                       input logic [TW-1:0] dw, input logic [TW-1:0] ti);
    tbl.push_back(mk(1, 0, p, d, 0, 4'd0, 6'b100000, 0, 0, 0, 0, pw, dw, ti));
    tbl.push_back(mk(1, 0, p, d, 0, 4'd1, 6'b000100, 0, 0, 0, 0, pw, dw, ti));
    tbl.push_back(mk(1, 0, p, d, 0, 4'd2, 6'b010000, 0, 0, 0, 0, pw, dw, ti));
    tbl.push_back(mk(1, 0, p, d, 0, 4'd3, 6'b000010, 0, 0, 0, 0, pw, dw, ti));
  endtask

  initial begin
    vec_t z;
    resetb = 1'b0; step = 1'b0; new_hand = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;

    // Hand 1: natural p=9 d=3, extra steps in S_DONE are ignored.
    deal4(9, 3, 0, 0, 0);
    tbl.push_back(mk(1, 0, 9, 3, 0, 4'd4, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 9, 3, 0, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 9, 3, 0, 4'd9, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 9, 3, 0, 4'd9, 0, 0, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 9, 3, 0, 4'd9, 0, 1, 1, 0, 1, 1, 0, 0));
    // Hand 2: p=5 d=6, player draws 7 (p->2), banker on 6 vs 7 draws, ends d=9.
    deal4(5, 6, 1, 0, 0);
    tbl.push_back(mk(1, 0, 5, 6, 0, 4'd4, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 5, 6, 7, 4'd5, 6'b001000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 2, 6, 7, 4'd6, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 2, 6, 7, 4'd7, 6'b000001, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 2, 9, 7, 4'd8, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 2, 9, 7, 4'd9, 0, 0, 0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 2, 9, 7, 4'd9, 0, 1, 0, 1, 1, 1, 1, 0));
    // Hand 3: p=4 d=3, player draws 8 (p->2), banker on 3 vs 8 stands.
    deal4(4, 3, 1, 1, 0);
    tbl.push_back(mk(1, 0, 4, 3, 0, 4'd4, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4, 3, 8, 4'd5, 6'b001000, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2, 3, 8, 4'd6, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2, 3, 8, 4'd8, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 2, 3, 8, 4'd9, 0, 0, 0, 1, 1, 1, 2, 0));
    tbl.push_back(mk(0, 1, 2, 3, 8, 4'd9, 0, 1, 0, 1, 1, 1, 2, 0));
    // Hand 4: p=6 d=6, both stand, tie.
    deal4(6, 6, 1, 2, 0);
    tbl.push_back(mk(1, 0, 6, 6, 0, 4'd4, 0, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(1, 0, 6, 6, 0, 4'd6, 0, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(1, 0, 6, 6, 0, 4'd8, 0, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 6, 6, 0, 4'd9, 0, 0, 1, 1, 1, 1, 2, 1));
    tbl.push_back(mk(0, 1, 6, 6, 0, 4'd9, 0, 1, 1, 1, 1, 1, 2, 1));
    // Hand 5: p=7 stands, banker on 4 draws; player wins 7 vs 4.
    deal4(7, 4, 1, 2, 1);
    tbl.push_back(mk(1, 0, 7, 4, 0, 4'd4, 0, 0, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(1, 0, 7, 4, 0, 4'd6, 0, 0, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(1, 0, 7, 4, 0, 4'd7, 6'b000001, 0, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(1, 0, 7, 4, 0, 4'd8, 0, 0, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(0, 0, 7, 4, 0, 4'd9, 0, 0, 1, 0, 1, 2, 2, 1));
    tbl.push_back(mk(0, 1, 7, 4, 0, 4'd9, 0, 1, 1, 0, 1, 2, 2, 1));
    // Hand 6: p=3 d=4, player draws a queen (v=0): banker on 4 stands.
    deal4(3, 4, 2, 2, 1);
    tbl.push_back(mk(1, 0, 3, 4, 0, 4'd4, 0, 0, 0, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 0, 3, 4, 12, 4'd5, 6'b001000, 0, 0, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 0, 3, 4, 12, 4'd6, 0, 0, 0, 0, 0, 2, 2, 1));
    tbl.push_back(mk(1, 0, 3, 4, 12, 4'd8, 0, 0, 0, 0, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 3, 4, 12, 4'd9, 0, 0, 0, 1, 1, 2, 3, 1));
    tbl.push_back(mk(0, 1, 3, 4, 12, 4'd9, 0, 1, 0, 1, 1, 2, 3, 1));

    // Reset state, with step held high to expose any ungated strobe.
    repeat (2) @(negedge clk);
    step = 1'b1;
    #1;
    z = mk(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_all("reset", z);
    @(posedge clk);
    #1;
    step = 1'b0;
    resetb = 1'b1;

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // Stall in S_P2 for 5 cycles with new_hand pulsing: nothing moves.
    apply("s5.p1", mk(1, 0, 9, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 2, 3, 1));
    apply("s5.d1", mk(1, 0, 9, 0, 0, 4'd1, 6'b000100, 0, 0, 0, 0, 2, 3, 1));
    for (int k = 0; k < 5; k++) begin
      apply($sformatf("s5.hold%0d", k),
            mk(0, 1'(k % 2 == 0), 9, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2, 3, 1));
    end
    apply("s5.p2", mk(1, 1, 9, 0, 0, 4'd2, 6'b010000, 0, 0, 0, 0, 2, 3, 1));
    apply("s5.d2", mk(1, 0, 9, 0, 0, 4'd3, 6'b000010, 0, 0, 0, 0, 2, 3, 1));
    apply("s5.nat", mk(1, 0, 9, 0, 0, 4'd4, 0, 0, 0, 0, 0, 2, 3, 1));
    apply("s5.res", mk(1, 0, 9, 0, 0, 4'd8, 0, 0, 0, 0, 0, 2, 3, 1));
    apply("s5.done", mk(0, 0, 9, 0, 0, 4'd9, 0, 0, 1, 0, 1, 3, 3, 1));
    apply("s5.new", mk(0, 1, 9, 0, 0, 4'd9, 0, 1, 1, 0, 1, 3, 3, 1));

    // Fourth player win: pwins must hold at 3.
    apply("s6.p1", mk(1, 0, 8, 1, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.d1", mk(1, 0, 8, 1, 0, 4'd1, 6'b000100, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.p2", mk(1, 0, 8, 1, 0, 4'd2, 6'b010000, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.d2", mk(1, 0, 8, 1, 0, 4'd3, 6'b000010, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.nat", mk(1, 0, 8, 1, 0, 4'd4, 0, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.res", mk(1, 0, 8, 1, 0, 4'd8, 0, 0, 0, 0, 0, 3, 3, 1));
    apply("s6.sat", mk(0, 0, 8, 1, 0, 4'd9, 0, 0, 1, 0, 1, 3, 3, 1));
    apply("s6.new", mk(0, 1, 8, 1, 0, 4'd9, 0, 1, 1, 0, 1, 3, 3, 1));

    // Reset asserted while in S_D3: outputs and tallies drop immediately.
    apply("r.p1", mk(1, 0, 7, 5, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 3, 3, 1));
    apply("r.d1", mk(1, 0, 7, 5, 0, 4'd1, 6'b000100, 0, 0, 0, 0, 3, 3, 1));
    apply("r.p2", mk(1, 0, 7, 5, 0, 4'd2, 6'b010000, 0, 0, 0, 0, 3, 3, 1));
    apply("r.d2", mk(1, 0, 7, 5, 0, 4'd3, 6'b000010, 0, 0, 0, 0, 3, 3, 1));
    apply("r.nat", mk(1, 0, 7, 5, 0, 4'd4, 0, 0, 0, 0, 0, 3, 3, 1));
    apply("r.bank", mk(1, 0, 7, 5, 0, 4'd6, 0, 0, 0, 0, 0, 3, 3, 1));
    apply("r.d3", mk(1, 0, 7, 5, 0, 4'd7, 6'b000001, 0, 0, 0, 0, 3, 3, 1));
    #1;
    resetb = 1'b0;
    #1;
    chk_all("r.async", z);
    @(posedge clk);
    #1;
    chk_all("r.held", z);
    resetb = 1'b1;
    step = 1'b0;
    apply("r.after", mk(1, 0, 7, 5, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    step = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
